// File: rtl/mdu_iter_if.sv
// Bus between the execute stage and the iterative RV32M multiply/divide unit.
// The master side issues the operation, the slave side (mdu_iter) returns the
// register-file write: result_o -> WD3, rd_addr_o -> addr_3, valid_o -> WE3.
interface mdu_iter_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic [4:0]      rd_addr_i;
    logic            busy_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_addr_o;

    modport master (
        output start_i, funct3_i, op_a_i, op_b_i, rd_addr_i,
        input  busy_o, valid_o, result_o, rd_addr_o
    );

    modport slave (
        input  start_i, funct3_i, op_a_i, op_b_i, rd_addr_i,
        output busy_o, valid_o, result_o, rd_addr_o
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit (execute stage).
// Multiplies by shift-add and divides by restoring division on operand
// magnitudes, one bit per clock, then applies the sign at the end.
// Define MDU_FAST_MUL_EN to resolve the whole MUL group with a combinational
// multiplier at start; otherwise no multiplier is inferred.
//
// state | meaning
// IDLE  | waiting for start_i; operands, funct3 and rd latched on acceptance
// CALC  | XLEN shift-add / restoring iterations, then one result-load cycle
// DONE  | valid_o strobe for one cycle, back to IDLE
module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic         clk_i,
    input  logic         reset_i,
    mdu_iter_if.slave    bus
);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        f3;
    logic [4:0]        rd_q;
    logic [4:0]        cnt;
    logic              last;
    logic              neg_res;
    logic              early;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN-1:0]   acc_hi;
    logic [XLEN-1:0]   acc_lo;
    logic [XLEN-1:0]   early_res;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_out_q;

    logic              is_div, a_sgn, b_sgn, a_neg, b_neg, neg_in;
    logic              div_zero, div_ovf, mul_zero, early_in;
    logic [XLEN-1:0]   mag_a_in, mag_b_in, early_res_in;
`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
`endif

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift, div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_sel, div_fix, final_res;

    // Operand decode at acceptance: magnitudes, result sign, early-resolved ops.
    always_comb begin
        is_div   = bus.funct3_i[2];
        a_sgn    = is_div ? ~bus.funct3_i[0] : (bus.funct3_i[1:0] != 2'b11);
        b_sgn    = is_div ? ~bus.funct3_i[0] : ~bus.funct3_i[1];
        a_neg    = a_sgn & bus.op_a_i[XLEN-1];
        b_neg    = b_sgn & bus.op_b_i[XLEN-1];
        mag_a_in = a_neg ? -bus.op_a_i : bus.op_a_i;
        mag_b_in = b_neg ? -bus.op_b_i : bus.op_b_i;
        // remainder follows the dividend, everything else the product of signs
        neg_in   = (is_div && bus.funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div && (bus.op_b_i == '0);
        div_ovf  = is_div && !bus.funct3_i[0] && (bus.op_a_i == MIN_NEG) && (bus.op_b_i == '1);
        mul_zero = (bus.funct3_i == 3'b000) && ((bus.op_a_i == '0) || (bus.op_b_i == '0));
        early_in = div_zero | div_ovf | mul_zero;
        early_res_in = '0;
        if (div_zero) begin
            early_res_in = bus.funct3_i[1] ? bus.op_a_i : '1;
        end else if (div_ovf) begin
            early_res_in = bus.funct3_i[1] ? '0 : MIN_NEG;
        end
`ifdef MDU_FAST_MUL_EN
        // sign-extend to 2*XLEN so the truncated product is correct for every mix
        fast_a    = {{XLEN{a_sgn & bus.op_a_i[XLEN-1]}}, bus.op_a_i};
        fast_b    = {{XLEN{b_sgn & bus.op_b_i[XLEN-1]}}, bus.op_b_i};
        fast_prod = fast_a * fast_b;
        if (!is_div) begin
            early_in     = 1'b1;
            early_res_in = (bus.funct3_i[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                                        : fast_prod[2*XLEN-1:XLEN];
        end
`endif
    end

    // One iteration step for both datapaths plus the final sign fix and select.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        // partial remainder < divisor, so bit XLEN of the difference is a clean borrow
        div_diff  = div_shift - {1'b0, mag_b};
        prod_fix  = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        div_sel   = f3[1] ? acc_hi : acc_lo;
        div_fix   = neg_res ? -div_sel : div_sel;
        if (early) begin
            final_res = early_res;
        end else if (f3[2]) begin
            final_res = div_fix;
        end else if (f3[1:0] == 2'b00) begin
            final_res = prod_fix[XLEN-1:0];
        end else begin
            final_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; early-resolved ops still spend one load cycle in CALC.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start_i) state_nxt = CALC;
            CALC:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, iteration registers and output registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            f3        <= '0;
            rd_q      <= '0;
            cnt       <= '0;
            last      <= 1'b0;
            neg_res   <= 1'b0;
            early     <= 1'b0;
            mag_b     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            early_res <= '0;
            result_q  <= '0;
            rd_out_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        f3        <= bus.funct3_i;
                        rd_q      <= bus.rd_addr_i;
                        mag_b     <= mag_b_in;
                        acc_hi    <= '0;
                        acc_lo    <= mag_a_in;
                        neg_res   <= neg_in;
                        early     <= early_in;
                        early_res <= early_res_in;
                        cnt       <= 5'd31;
                        last      <= early_in;
                    end
                end
                CALC: begin
                    if (last) begin
                        result_q <= final_res;
                        rd_out_q <= rd_q;
                        last     <= 1'b0;
                    end else begin
                        if (f3[2]) begin
                            if (!div_diff[XLEN]) begin
                                acc_hi <= div_diff[XLEN-1:0];
                                acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
                            end else begin
                                acc_hi <= div_shift[XLEN-1:0];
                                acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
                            end
                        end else begin
                            {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
                        end
                        cnt <= cnt - 5'd1;
                        if (cnt == 5'd0) last <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o    = (state != IDLE);
    assign bus.valid_o   = (state == DONE);
    assign bus.result_o  = result_q;
    assign bus.rd_addr_o = rd_out_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: the driver pushes the expected write-back
// (value, rd, strobe cycle) when an op is accepted; the monitor pops on valid_o.
module tb_mdu_iter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mdu_iter_if #(.XLEN(32)) bus ();
    mdu_iter #(.XLEN(32)) dut (.clk_i(clk), .reset_i(reset), .bus(bus));

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          at;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_res;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural values.
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] ua = {32'h0, a};
        logic [63:0] ub = {32'h0, b};
        logic [63:0] p;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit early;
        early = (f[2] && b == 0)
             || ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
             || (f == 3'd0 && (a == 0 || b == 0));
`ifdef MDU_FAST_MUL_EN
        if (!f[2]) early = 1'b1;
`endif
        return early ? 1 : 33;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.valid_o) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got strobe with result %h, required no strobe", bus.result_o);
            end else begin
                mon_e = sb_q.pop_front();
                check("result", bus.result_o, mon_e.res);
                check("rd_addr", 32'(bus.rd_addr_o), 32'(mon_e.rd));
                check("valid_cycle", 32'(cyc), 32'(mon_e.at));
                check("busy_at_valid", 32'(bus.busy_o), 32'd1);
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int c0, output bit ok);
        bus.start_i   = 1'b1;
        bus.funct3_i  = f;
        bus.op_a_i    = a;
        bus.op_b_i    = b;
        bus.rd_addr_i = rd;
        ok = 1'b0;
        c0 = 0;
        for (int n = 0; n < 80; n++) begin
            @(posedge clk);
            #1;
            if (bus.busy_o) begin
                ok = 1'b1;
                c0 = cyc;
                break;
            end
        end
        check("accept", 32'(ok), 32'd1);
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit hold);
        int   c0;
        bit   ok;
        int   lat;
        int   busy_n;
        exp_t e;
        lat = ref_lat(f, a, b);
        issue(f, a, b, rd, c0, ok);
        if (!ok) begin
            bus.start_i = 1'b0;
            return;
        end
        e.res = ref_res(f, a, b);
        e.rd  = rd;
        e.at  = c0 + lat;
        sb_q.push_back(e);
        last_res = e.res;
        if (hold) begin
            // keep requesting with scrambled operands; none of it may be taken
            for (int n = 0; n < 80; n++) begin
                @(negedge clk);
                if (bus.valid_o) break;
                bus.funct3_i  = 3'($urandom);
                bus.op_a_i    = $urandom;
                bus.op_b_i    = $urandom;
                bus.rd_addr_i = 5'($urandom);
            end
        end else begin
            busy_n = 0;
            for (int n = 0; n < 80; n++) begin
                @(negedge clk);
                bus.start_i = 1'b0;
                if (bus.busy_o) busy_n++;
                else break;
            end
            check("busy_cycles", 32'(busy_n), 32'(lat + 1));
        end
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } op_t;

    op_t dir_ops[$] = '{
        '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5},
        '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6},
        '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7},
        '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8},
        '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9},
        '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10},
        '{3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 5'd11},
        '{3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 5'd12},
        '{3'd4, 32'h0000_0005, 32'h0000_0000, 5'd13},
        '{3'd6, 32'h0000_0005, 32'h0000_0000, 5'd14},
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15},
        '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16},
        '{3'd0, 32'h0000_0000, 32'h1234_5678, 5'd0},
        '{3'd0, 32'h0001_0000, 32'h0001_0000, 5'd17},
        '{3'd3, 32'h0001_0000, 32'h0001_0000, 5'd18}
    };

    initial begin
        bit hold;
        bus.start_i   = 1'b0;
        bus.funct3_i  = '0;
        bus.op_a_i    = '0;
        bus.op_b_i    = '0;
        bus.rd_addr_i = '0;
        last_res      = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy_o), 32'd0);
        check("reset_valid", 32'(bus.valid_o), 32'd0);
        check("reset_result", bus.result_o, 32'd0);
        check("reset_rd", 32'(bus.rd_addr_o), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        foreach (dir_ops[i]) do_op(dir_ops[i].f, dir_ops[i].a, dir_ops[i].b, dir_ops[i].rd, 1'b0);
        repeat (5) @(negedge clk);
        check("result_holds", bus.result_o, last_res);

        // start held through busy, then a back-to-back op
        do_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd21, 1'b1);
        do_op(3'd5, 32'd1000, 32'd7, 5'd22, 1'b0);

        // abort mid-CALC: everything must clear at once with no strobe
        begin
            int c0;
            bit ok;
            issue(3'd5, 32'd5000, 32'd3, 5'd23, c0, ok);
            @(negedge clk);
            bus.start_i = 1'b0;
            repeat (9) @(posedge clk);
            #2;
            reset = 1'b1;
            #1;
            check("abort_busy", 32'(bus.busy_o), 32'd0);
            check("abort_valid", 32'(bus.valid_o), 32'd0);
            check("abort_result", bus.result_o, 32'd0);
            check("abort_rd", 32'(bus.rd_addr_o), 32'd0);
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
        end
        do_op(3'd7, 32'd100, 32'd7, 5'd24, 1'b0);

        for (int i = 0; i < 60; i++) begin
            hold = ($urandom_range(0, 3) == 0) && (i != 59);
            do_op(3'($urandom), rand_operand(), rand_operand(), 5'($urandom), hold);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int n = 0; n < 100; n++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
